// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-serial load port of the instruction ROM loader.
// INST_ROM_CHECKSUM_EN adds the ld_sum running checksum signal.
interface inst_rom_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  ce;
    logic [31:0]           addr;
    logic [31:0]           inst;
    logic                  ld_start;
    logic [ADDR_WIDTH:0]   ld_len;
    logic                  ld_valid;
    logic [7:0]            ld_byte;
    logic                  ld_ready;
    logic                  ld_busy;
    logic                  ld_done;
    logic [ADDR_WIDTH:0]   ld_count;
`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0]           ld_sum;

    modport master (
        output ce, addr, ld_start, ld_len, ld_valid, ld_byte,
        input  inst, ld_ready, ld_busy, ld_done, ld_count, ld_sum
    );
    modport slave (
        input  ce, addr, ld_start, ld_len, ld_valid, ld_byte,
        output inst, ld_ready, ld_busy, ld_done, ld_count, ld_sum
    );
`else
    modport master (
        output ce, addr, ld_start, ld_len, ld_valid, ld_byte,
        input  inst, ld_ready, ld_busy, ld_done, ld_count
    );
    modport slave (
        input  ce, addr, ld_start, ld_len, ld_valid, ld_byte,
        output inst, ld_ready, ld_busy, ld_done, ld_count
    );
`endif
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM with zero-latency fetch and a byte-serial, big-endian load engine.
// Optional INST_ROM_CHECKSUM_EN: adds ld_sum, the mod-2^32 sum of words written by a load.
//
// state | meaning
// IDLE  | waiting for ld_start; fetch path live
// LOAD  | accepting bytes, writing one word per 4 bytes
// DONE  | one-cycle ld_done pulse, then back to IDLE
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    inst_rom_loader_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   len_q;
    logic [1:0]      byte_idx;
    logic [23:0]     word_q;
    logic [31:0]     mem [DEPTH];

    logic            wr_en;
    logic [31:0]     wr_data;
    logic [CW-1:0]   count_inc;
    logic            in_range;
    logic            unused_addr_lsb;

    assign wr_en     = (state == LOAD) && bus.ld_valid && (byte_idx == 2'd3);
    assign wr_data   = {word_q, bus.ld_byte};
    assign count_inc = bus.ld_count + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            len_q        <= '0;
            byte_idx     <= 2'd0;
            word_q       <= '0;
            bus.ld_count <= '0;
            bus.ld_ready <= 1'b0;
            bus.ld_busy  <= 1'b0;
            bus.ld_done  <= 1'b0;
        end else begin
            bus.ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ld_start) begin
                        len_q        <= bus.ld_len;
                        bus.ld_count <= '0;
                        byte_idx     <= 2'd0;
                        word_q       <= '0;
                        bus.ld_busy  <= 1'b1;
                        if (bus.ld_len == '0) begin
                            state       <= DONE;
                            bus.ld_done <= 1'b1;
                        end else begin
                            state        <= LOAD;
                            bus.ld_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.ld_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_q[23:16] <= bus.ld_byte;
                            2'd1: word_q[15:8]  <= bus.ld_byte;
                            2'd2: word_q[7:0]   <= bus.ld_byte;
                            default: begin
                                bus.ld_count <= count_inc;
                                if (count_inc == len_q) begin
                                    state        <= DONE;
                                    bus.ld_ready <= 1'b0;
                                    bus.ld_done  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.ld_busy <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.ld_ready <= 1'b0;
                    bus.ld_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset so a mid-load reset keeps already written words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.ld_count[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ld_sum <= '0;
        end else if (state == IDLE && bus.ld_start) begin
            bus.ld_sum <= '0;
        end else if (wr_en) begin
            bus.ld_sum <= bus.ld_sum + wr_data;
        end
    end
`endif

    assign in_range        = (bus.addr[31:ADDR_WIDTH+2] == '0);
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Fetch returns NOP while loading so the core never sees a half-written image.
    always_comb begin
        bus.inst = 32'h0;
        if (bus.ce && !bus.ld_busy && in_range) begin
            bus.inst = mem[bus.addr[ADDR_WIDTH+1:2]];
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: reset state, loads with and without gaps,
// fetch gating, ignored restart, zero-length load, mid-load reset, address range.
module tb_inst_rom_loader;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_pulses = 0;
    int   t_b2b;
    int   t_gap;

    inst_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

    inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.ld_done) done_pulses++;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.ce   = 1'b1;
        bus.addr = a;
        #1;
        check_vec(tag, bus.inst, exp);
        bus.ce   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    // Runs a complete load; returns ticks from the start edge up to the edge raising ld_done.
    task automatic run_load(input logic [10:0] len, input logic [7:0] bytes [8],
                            input int nbytes, input bit gap, output int ticks);
        bus.ld_start = 1'b1;
        bus.ld_len   = len;
        tick();
        bus.ld_start = 1'b0;
        ticks = 1;
        for (int i = 0; i < nbytes; i++) begin
            if (gap) begin
                bus.ld_valid = 1'b0;
                tick();
                ticks++;
            end
            send_byte(bytes[i]);
            ticks++;
        end
    endtask

    logic [7:0] img [8];

    initial begin
        img = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h20, 8'h21, 8'h00, 8'h02};
        bus.ce = 1'b0; bus.addr = 32'h0000_0123;
        bus.ld_start = 1'b0; bus.ld_len = '0; bus.ld_valid = 1'b0; bus.ld_byte = '0;

        repeat (2) tick();
        check_vec("rst_inst",  bus.inst, 32'h0);
        check_vec("rst_ready", {31'h0, bus.ld_ready}, 32'h0);
        check_vec("rst_busy",  {31'h0, bus.ld_busy}, 32'h0);
        check_vec("rst_count", {21'h0, bus.ld_count}, 32'h0);
        rst = 1'b1;
        tick();
        check_vec("idle_ready", {31'h0, bus.ld_ready}, 32'h0);

        // Back-to-back load, peek at ready/fetch gating on the way in
        bus.ld_start = 1'b1; bus.ld_len = 11'd2;
        tick();
        bus.ld_start = 1'b0;
        check_vec("load_ready", {31'h0, bus.ld_ready}, 32'h1);
        check_vec("load_busy",  {31'h0, bus.ld_busy}, 32'h1);
        fetch("fetch_in_load", 32'h0, 32'h0);
        t_b2b = 1;
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i]);
            t_b2b++;
        end
        check_vec("b2b_done",  {31'h0, bus.ld_done}, 32'h1);
        check_vec("b2b_count", {21'h0, bus.ld_count}, 32'h2);
        check_vec("b2b_busy_in_done", {31'h0, bus.ld_busy}, 32'h1);
`ifdef INST_ROM_CHECKSUM_EN
        check_vec("b2b_sum", bus.ld_sum, 32'h5423_0003);
`endif
        tick();
        check_vec("done_fall", {31'h0, bus.ld_done}, 32'h0);
        check_vec("busy_fall", {31'h0, bus.ld_busy}, 32'h0);
        check_vec("done_pulses_1", done_pulses, 32'd1);
        fetch("fetch_a0", 32'h0, 32'h3402_0001);
        fetch("fetch_a4", 32'h4, 32'h2021_0002);
        fetch("fetch_a6", 32'h6, 32'h2021_0002);

        // ld_valid outside LOAD does nothing
        send_byte(8'hFF);
        check_vec("idle_valid_count", {21'h0, bus.ld_count}, 32'h2);

        // Same load with a gap before every byte
        run_load(11'd2, img, 8, 1'b1, t_gap);
        check_vec("gap_done", {31'h0, bus.ld_done}, 32'h1);
        check_vec("gap_delay", t_gap - t_b2b, 32'd8);
        tick();
        fetch("gap_a0", 32'h0, 32'h3402_0001);
        fetch("gap_a4", 32'h4, 32'h2021_0002);

        // Restart attempt mid-load is ignored
        bus.ld_start = 1'b1; bus.ld_len = 11'd2;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        bus.ld_start = 1'b1; bus.ld_len = 11'd0;
        tick();
        bus.ld_start = 1'b0;
        check_vec("restart_count", {21'h0, bus.ld_count}, 32'h1);
        check_vec("restart_ready", {31'h0, bus.ld_ready}, 32'h1);
        for (int i = 4; i < 8; i++) send_byte(img[i]);
        check_vec("restart_done",  {31'h0, bus.ld_done}, 32'h1);
        check_vec("restart_final", {21'h0, bus.ld_count}, 32'h2);
        tick();

        // Zero-length load
        bus.ld_start = 1'b1; bus.ld_len = 11'd0;
        tick();
        bus.ld_start = 1'b0;
        check_vec("zero_done",  {31'h0, bus.ld_done}, 32'h1);
        check_vec("zero_count", {21'h0, bus.ld_count}, 32'h0);
        check_vec("zero_ready", {31'h0, bus.ld_ready}, 32'h0);
        tick();
        check_vec("zero_idle", {31'h0, bus.ld_busy}, 32'h0);
        fetch("zero_a0", 32'h0, 32'h3402_0001);
        check_vec("done_pulses_4", done_pulses, 32'd4);

        // Reset after 6 bytes of a 3-word load
        bus.ld_start = 1'b1; bus.ld_len = 11'd3;
        tick();
        bus.ld_start = 1'b0;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b0;
        #2;
        check_vec("mid_rst_count", {21'h0, bus.ld_count}, 32'h0);
        check_vec("mid_rst_busy",  {31'h0, bus.ld_busy}, 32'h0);
        check_vec("mid_rst_ready", {31'h0, bus.ld_ready}, 32'h0);
`ifdef INST_ROM_CHECKSUM_EN
        check_vec("mid_rst_sum", bus.ld_sum, 32'h0);
`endif
        #2;
        rst = 1'b1;
        tick();
        check_vec("mid_rst_no_done", {31'h0, bus.ld_done}, 32'h0);
        fetch("mid_rst_w0", 32'h0, 32'hAABB_CCDD);
        fetch("mid_rst_w1", 32'h4, 32'h2021_0002);
        check_vec("done_pulses_end", done_pulses, 32'd4);

        // Out-of-range fetch addresses
        fetch("oor_1000", 32'h0000_1000, 32'h0);
        fetch("oor_msb",  32'h8000_0004, 32'h0);
        bus.ce = 1'b0; bus.addr = 32'h0;
        #1;
        check_vec("ce_low", bus.inst, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
